bus_transfer_controller: RTL and testbench
==========================================

BUS_TRANSFER_CONTROLLER -- requirements
Module: bus_transfer_controller

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of buffered registers on the shared 16-bit bus.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: bus-settle cycles before latch; legal range 1-15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1: transfer request present.
REQ-006 SHALL have port req_ready  output  1: controller accepts a request this cycle.
REQ-007 SHALL have port req_src  input  clog2(NUM_REGS): source register index (driver).
REQ-008 SHALL have port req_dst  input  clog2(NUM_REGS): destination register index (latcher).
REQ-009 SHALL have port enable  output  NUM_REGS: one-hot-or-zero bus-drive enables, one per register.
REQ-010 SHALL have port latch  output  NUM_REGS: one-hot-or-zero capture strobes, one per register.
REQ-011 SHALL have port busy  output  1: transfer in progress.
REQ-012 SHALL have port done  output  1: one-cycle pulse at transfer completion.
REQ-013 SHALL have port err  output  1: one-cycle pulse, concurrent with done, for a rejected request.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-015 SHALL register req_src and req_dst at acceptance; later input changes SHALL have no effect on the current transfer.
REQ-016 SHALL implement FSM states IDLE, DRIVE, LATCH, HOLD, DONE.
REQ-017 IDLE -> DRIVE on acceptance of a valid request; IDLE -> DONE, with err, on acceptance of a rejected request.
REQ-018 SHALL reject a request when req_src equals req_dst or either index is at least NUM_REGS; a rejected request SHALL assert no enable or latch bit.
REQ-019 DRIVE: enable[src]=1, latch=0; SHALL remain in DRIVE for the settle length, then go to LATCH.
REQ-020 LATCH: enable[src]=1 and latch[dst]=1 for exactly one cycle, then go to HOLD.
REQ-021 HOLD: enable[src]=1, latch=0 for one cycle (bus hold after capture), then go to DONE.
REQ-022 DONE: enable=0, latch=0, done=1 for one cycle, then go to IDLE.
REQ-023 enable and latch SHALL be registered outputs and SHALL never have more than one bit set each.
REQ-024 latch SHALL never be asserted without enable asserted in the same cycle.
REQ-025 busy SHALL be 1 in DRIVE, LATCH, HOLD and DONE.
REQ-026 A valid transfer SHALL last SETTLE_CYCLES+3 cycles from acceptance to the last done cycle; the next request SHALL be accepted in the cycle after DONE.

Reset
REQ-027 On rst=1 the FSM SHALL enter IDLE immediately, without waiting for a clock edge.
REQ-028 On rst=1 enable, latch, done, err and the settle counter SHALL be 0, and req_ready SHALL be 1.
REQ-029 Reset during any state SHALL abort the transfer with no latch pulse and no done pulse.

Configuration
REQ-030 With macro BUS_XFER_SETTLE_EN defined, DRIVE SHALL last exactly SETTLE_CYCLES cycles, timed by a 4-bit down-counter.
REQ-031 With BUS_XFER_SETTLE_EN undefined, DRIVE SHALL last exactly 1 cycle, SETTLE_CYCLES SHALL be ignored, and no counter SHALL be built.

Structure
REQ-032 FSM state encodings SHALL live in a shared header, bus_defs.vh, next to the register modules.
REQ-033 The 16-bit bus width constant SHALL live in bus_defs.vh.
REQ-034 SHALL use one sub-module, onehot_decoder (index plus valid to NUM_REGS one-hot), instantiated once for enable and once for latch.

Verification
REQ-035 Scenario: reset, then src=0, dst=1 with settle enabled and SETTLE_CYCLES=2 -> enable[0] high for 4 cycles; latch[1] high only in the 3rd of them; done pulses in cycle 5.
REQ-036 Scenario: the same transfer with BUS_XFER_SETTLE_EN undefined -> enable[0] high for 3 cycles; latch[1] in the 2nd; done in the 4th.
REQ-037 Scenario: src=3, dst=3 -> err and done pulse one cycle after acceptance; enable and latch stay 0.
REQ-038 Scenario: with two real registers attached, register A preloaded with 16'h5B4E, transfer A->B -> register B reads 16'h5B4E after done.
REQ-039 Scenario: assert rst mid-LATCH -> all outputs 0 within the same timestep; no done pulse; next request is accepted normally.
REQ-040 Scenario: hold req_valid=1 back-to-back with changing indices -> only IDLE-cycle handshakes are accepted; req_ready stays 0 while busy=1.

Source files
------------

// File: rtl/bus_transfer_controller_pkg.sv
// Shared bus definitions: data bus width, controller FSM encoding, index-width helper.
package bus_transfer_controller_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        LATCH = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_transfer_controller_onehot_decoder.sv
// Index + valid to one-hot (or all-zero) vector; purely combinational, out-of-range index yields zero.
module onehot_decoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             vld,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (vld && (int'(idx) < N)) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences one register-to-register move on the shared bus: drive, settle, latch, hold, done.
// Valid transfer spans SETTLE_CYCLES+3 cycles (BUS_XFER_SETTLE_EN) or 4 cycles otherwise; req_ready only in IDLE.
module bus_transfer_controller
    import bus_transfer_controller_pkg::*;
#(
    parameter  int NUM_REGS      = 8,
    parameter  int SETTLE_CYCLES = 2,
    localparam int IDX_W         = idx_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    output logic [NUM_REGS-1:0] enable,
    output logic [NUM_REGS-1:0] latch,
    output logic                busy,
    output logic                done,
    output logic                err
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..15");
    end

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     src;
    logic [IDX_W-1:0]     dst;
    logic [IDX_W-1:0]     src_nxt;
    logic [IDX_W-1:0]     dst_nxt;
    logic                 bad;
    logic                 accept;
    logic                 reject;
    logic                 settle_last;
    logic                 en_vld;
    logic                 lat_vld;
    logic [NUM_REGS-1:0]  enable_nxt;
    logic [NUM_REGS-1:0]  latch_nxt;

    assign accept = req_valid && (state == IDLE);
    assign reject = (req_src == req_dst) ||
                    (int'(req_src) >= NUM_REGS) ||
                    (int'(req_dst) >= NUM_REGS);

`ifdef BUS_XFER_SETTLE_EN
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    logic [3:0] settle_cnt;

    // Loaded at acceptance so the count is already primed on the first DRIVE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == DRIVE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    assign settle_last = (settle_cnt == 4'd0);
`else
    assign settle_last = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reject ? DONE : DRIVE;
            DRIVE:   if (settle_last) state_nxt = LATCH;
            LATCH:   state_nxt = HOLD;
            HOLD:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the flops present them in the state they belong to.
    always_comb begin
        src_nxt = accept ? req_src : src;
        dst_nxt = accept ? req_dst : dst;
        en_vld  = (state_nxt == DRIVE) || (state_nxt == LATCH) || (state_nxt == HOLD);
        lat_vld = (state_nxt == LATCH);
    end

    onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_enable_dec (
        .idx    (src_nxt),
        .vld    (en_vld),
        .onehot (enable_nxt)
    );

    onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_latch_dec (
        .idx    (dst_nxt),
        .vld    (lat_vld),
        .onehot (latch_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
            latch  <= '0;
            src    <= '0;
            dst    <= '0;
            bad    <= 1'b0;
        end else begin
            enable <= enable_nxt;
            latch  <= latch_nxt;
            if (accept) begin
                src <= req_src;
                dst <= req_dst;
                bad <= reject;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && bad;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed bench: six registers on a modelled 16-bit bus around bus_transfer_controller.
module tb_bus_transfer_controller;
    import bus_transfer_controller_pkg::*;

    localparam int NR = 6;
    localparam int IW = 3;
`ifdef BUS_XFER_SETTLE_EN
    localparam int DL = 2;
`else
    localparam int DL = 1;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_src;
    logic [IW-1:0] req_dst;
    logic [NR-1:0] enable;
    logic [NR-1:0] latch;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    bus_transfer_controller #(.NUM_REGS(NR), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .enable    (enable),
        .latch     (latch),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [BUS_W-1:0] regs [NR];
    logic [BUS_W-1:0] bus;
    logic             pre_vld;
    int               pre_idx;
    logic [BUS_W-1:0] pre_dat;

    always_comb begin
        bus = '0;
        for (int i = 0; i < NR; i++) if (enable[i]) bus = bus | regs[i];
    end

    always @(posedge clk) begin
        if (pre_vld) regs[pre_idx] <= pre_dat;
        else for (int i = 0; i < NR; i++) if (latch[i]) regs[i] <= bus;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int oh(input int i);
        return (i >= 0 && i < NR) ? (1 << i) : 0;
    endfunction

    task automatic wait_idle();
        for (int c = 0; c < 20 && !req_ready; c++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", int'(req_ready), 1);
    endtask

    task automatic preload(input int idx, input logic [BUS_W-1:0] d);
        pre_vld = 1'b1; pre_idx = idx; pre_dat = d;
        @(posedge clk); #1;
        pre_vld = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input int src, input int dst, input bit rejected);
        int en_n, lat_at, done_at, err_at, viol;
        wait_idle();
        req_valid = 1'b1; req_src = IW'(src); req_dst = IW'(dst);
        @(posedge clk); #1;
        req_valid = 1'b0; req_src = IW'(dst); req_dst = IW'(src);
        en_n = 0; lat_at = 0; done_at = 0; err_at = 0; viol = 0;
        for (int c = 1; c <= 12; c++) begin
            if (enable != 0) begin
                if (int'(enable) == oh(src)) en_n++; else viol++;
            end
            if (latch != 0) begin
                if (int'(latch) != oh(dst) || int'(enable) != oh(src) || lat_at != 0) viol++;
                lat_at = c;
            end
            if (done) begin
                if (done_at != 0) viol++;
                done_at = c;
            end
            if (err) err_at = c;
            if (busy == req_ready) viol++;
            @(posedge clk); #1;
        end
        chk({tag, "_en_cycles"}, en_n,    rejected ? 0 : DL + 2);
        chk({tag, "_latch_at"},  lat_at,  rejected ? 0 : DL + 1);
        chk({tag, "_done_at"},   done_at, rejected ? 1 : DL + 3);
        chk({tag, "_err_at"},    err_at,  rejected ? 1 : 0);
        chk({tag, "_viol"},      viol,    0);
    endtask

    initial begin
        int seen, dn, lt, acc, viol, pend;
        bit chk_next;
        clk = 1'b0; rst = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0;
        pre_vld = 1'b0; pre_idx = 0; pre_dat = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_enable", int'(enable),    0);
        chk("rst_latch",  int'(latch),     0);
        chk("rst_done",   int'(done),      0);
        chk("rst_err",    int'(err),       0);
        chk("rst_busy",   int'(busy),      0);
        chk("rst_ready",  int'(req_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_xfer("x01", 0, 1, 1'b0);
        check_xfer("x33", 3, 3, 1'b1);
        check_xfer("x61", 6, 1, 1'b1);
        check_xfer("x17", 1, 7, 1'b1);
        check_xfer("x50", 5, 0, 1'b0);

        preload(4, 16'h0000);
        preload(2, 16'h5B4E);
        check_xfer("x24", 2, 4, 1'b0);
        chk("reg_b", int'(regs[4]), 'h5B4E);
        chk("reg_a", int'(regs[2]), 'h5B4E);

        // Reset while LATCH is on the outputs.
        wait_idle();
        req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (latch != 0) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rl_seen", seen, 1);
        rst = 1'b1;
        #1;
        chk("rl_enable", int'(enable),    0);
        chk("rl_latch",  int'(latch),     0);
        chk("rl_done",   int'(done),      0);
        chk("rl_busy",   int'(busy),      0);
        chk("rl_ready",  int'(req_ready), 1);
        @(posedge clk); #1 rst = 1'b0;
        dn = 0; lt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            if (latch != 0) lt++;
            @(posedge clk); #1;
        end
        chk("rl_no_done",  dn, 0);
        chk("rl_no_latch", lt, 0);
        check_xfer("xpost", 1, 2, 1'b0);

        // Back-to-back requests with indices changing every cycle.
        wait_idle();
        acc = 0; viol = 0; pend = 0; chk_next = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 3 * (DL + 4); k++) begin
            req_src = IW'(k % NR);
            req_dst = IW'((k + 1) % NR);
            if (chk_next) begin
                if (int'(enable) != oh(pend)) viol++;
                chk_next = 1'b0;
            end
            if (busy == req_ready) viol++;
            if (req_ready) begin
                acc++;
                pend = k % NR;
                chk_next = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_viol", viol, 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
